rr_mux4: RTL and testbench

- Four-channel round-robin multiplexer: the collecting end of the team's 1-to-4 demultiplexer path.
- Merges four valid/ready input streams into one registered output stream.
- Tags each output beat with the 2-bit channel number it came from, so a downstream dmux can route it back out.
- Packet-aware: once a channel is granted, the grant holds until that channel's last beat.

---
 rtl/rr_mux4.sv | 166 ++++++++++++++++
 tb/tb_rr_mux4.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// Four-channel round-robin stream multiplexer with packet lock.
// Merges four valid/ready channels into one registered output stream. Each output
// beat carries the number of the channel it came from. A granted channel keeps the
// grant until it sends its last beat.
module rr_mux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_last,
  input  logic               out_ready
);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       lock_ch_q, lock_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;

  logic             can_load;
  logic [1:0]       grant;
  logic             grant_found;
  logic [1:0]       sel_ch;
  logic             sel_active;
  logic             take;
  logic [WIDTH-1:0] sel_data;

  // The output register can take a new beat when empty or when it is being drained.
  assign can_load = !out_valid_q || out_ready;

  // Rotating-priority search from rr_ptr; the descending walk lets the lowest offset win.
  always_comb begin
    grant       = rr_ptr_q;
    grant_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[rr_ptr_q + 2'(k)]) begin
        grant       = rr_ptr_q + 2'(k);
        grant_found = 1'b1;
      end
    end
  end

  // Pick the channel that owns the input side this cycle.
  // While locked, the owner gets ready even when it is not valid, so it can resume at once.
  always_comb begin
    sel_ch     = grant;
    sel_active = grant_found;
    unique case (state_q)
      StArb: begin
        sel_ch     = grant;
        sel_active = grant_found;
      end
      StLocked: begin
        sel_ch     = lock_ch_q;
        sel_active = 1'b1;
      end
      default: ;
    endcase
  end

  // Ready goes only to the selected channel and is held low while in reset.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && sel_active) begin
      in_ready[sel_ch] = can_load;
    end
  end

  assign take = in_valid[sel_ch] && in_ready[sel_ch];

  // Data mux for the selected channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_ch == 2'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for arbitration state, pointer, lock and output register.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;

    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = sel_ch;
      out_last_d  = in_last[sel_ch];
      unique case (state_q)
        StArb: begin
          rr_ptr_d = grant + 2'd1;
          if (!in_last[grant]) begin
            state_d   = StLocked;
            lock_ch_d = grant;
          end
        end
        StLocked: begin
          // Pointer is frozen while locked; it already moved past this channel at grant.
          if (in_last[lock_ch_q]) begin
            state_d = StArb;
          end
        end
        default: ;
      endcase
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StArb;
      rr_ptr_q    <= 2'd0;
      lock_ch_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

  // At most one channel is ever offered ready.
  a_ready_onehot0: assert property (@(posedge clk) $onehot0(in_ready));

  // While locked, no channel other than the owner sees ready.
  a_lock_exclusive: assert property (@(posedge clk) disable iff (rst)
    (state_q == StLocked) |-> ((in_ready & ~(4'b0001 << lock_ch_q)) == 4'b0000));

  // A stalled output beat stays put until it is taken.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_sel) && $stable(out_last)));

endmodule

// File: tb/tb_rr_mux4.sv
// Bench for rr_mux4: table of per-cycle stimulus with hand-derived expectations,
// plus a scoreboard queue that checks every output beat's data, channel and last flag.
module tb_rr_mux4;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_last;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_last;
  logic               out_ready;

  rr_mux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; exp_rdy is checked before the edge, exp_ov/sel/last after it.
  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [7:0] base;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic       exp_last;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Channel c carries base + 16*c, so every channel's data is distinct within a row.
  function automatic logic [7:0] chan_data(logic [7:0] base, int ch);
    return base + 8'(ch * 16);
  endfunction

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic o, logic [7:0] b,
                              logic [3:0] er, logic eov, logic [1:0] es, logic el);
    vec_t t;
    t.rst = r; t.v = v; t.l = l; t.ordy = o; t.base = b;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = es; t.exp_last = el;
    return t;
  endfunction

  task automatic check(string name, int row, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d got %0h want %0h", name, row, got, want);
    end
  endtask

  task automatic run_row(int i, vec_t r);
    beat_t exp;
    int    ch;
    rst       = r.rst;
    in_valid  = r.v;
    in_last   = r.l;
    out_ready = r.ordy;
    for (int c = 0; c < 4; c++) in_data[c*WIDTH +: WIDTH] = chan_data(r.base, c);

    @(negedge clk);
    check("in_ready", i, 32'(in_ready), 32'(r.exp_rdy));
    // An output beat leaves at the coming edge: compare it with the oldest expected beat.
    if (!r.rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow row %0d got beat sel %0d want none", i, out_sel);
      end else begin
        exp = sb.pop_front();
        check("out_data", i, 32'(out_data), 32'(exp.data));
        check("beat_sel", i, 32'(out_sel), 32'(exp.sel));
        check("beat_last", i, 32'(out_last), 32'(exp.last));
      end
    end
    if (r.rst) begin
      sb.delete();
    end else if ((r.exp_rdy & r.v) != 4'b0000) begin
      ch = 0;
      for (int c = 0; c < 4; c++) if (r.exp_rdy[c]) ch = c;
      exp.sel  = 2'(ch);
      exp.data = chan_data(r.base, ch);
      exp.last = r.l[ch];
      sb.push_back(exp);
    end

    @(posedge clk);
    #1;
    check("out_valid", i, 32'(out_valid), 32'(r.exp_ov));
    if (r.exp_ov) begin
      check("out_sel", i, 32'(out_sel), 32'(r.exp_sel));
      check("out_last", i, 32'(out_last), 32'(r.exp_last));
    end
    if (r.rst) begin
      check("rst_data", i, 32'(out_data), 32'(0));
      check("rst_sel", i, 32'(out_sel), 32'(0));
      check("rst_last", i, 32'(out_last), 32'(0));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0; in_last = 4'b0; in_data = '0; out_ready = 1'b0;

    //                 rst v        l        rdy base   exp_rdy  ov sel   last
    // Reset state.
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Fairness: all valid, single-beat packets -> 0,1,2,3,0,1.
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h01, 4'b0001, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h02, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h03, 4'b0100, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h04, 4'b1000, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 4'b0001, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h06, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Packet lock: rr_ptr=2, channel 2 sends A1,A2,A3 while channel 0 waits.
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 1, 8'h81, 4'b0100, 1, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 1, 8'h82, 4'b0100, 1, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0101, 1, 8'h83, 4'b0100, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'h90, 4'b0001, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Backpressure: channel 1 beat 0x5A held for 5 stalled cycles, then 0x5B loads.
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 0, 8'h4A, 4'b0010, 1, 2'd1, 1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 4'b0010, 4'b0010, 0, 8'h4A, 4'b0000, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'h4B, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Wrap and skip: grant 2 makes rr_ptr=3; lone channel 1 wins; then 2 beats 1.
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h30, 4'b0100, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'h31, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 1, 8'h32, 4'b0100, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Stall in LOCKED: channel 1 non-last beat, valid dropped 4 cycles, channel 0 ignored.
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h60, 4'b0010, 1, 2'd1, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'h61, 4'b0010, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 8'h62, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'h63, 4'b0001, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Reset mid-packet: channel 3 beat 1, reset during beat 2 drops the held beat.
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'hC0, 4'b1000, 1, 2'd3, 0));
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 0, 8'hC1, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 8'hC2, 4'b0001, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));
    // Reset with rr_ptr=2 must restart the search at 0: channels 1 and 3 -> 1 wins.
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'hD0, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 8'hD1, 4'b0010, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2'd0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) run_row(i, vecs[i]);

    // Every beat accepted on the input side must have come out.
    check("sb_empty", vecs.size(), 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
